// File: rtl/lcd_cmd_arbiter_if.sv
// rtl/lcd_cmd_arbiter_if.sv - requester and controller signal bundle for lcd_cmd_arbiter
interface lcd_cmd_arbiter_if;
    logic       ireq0;
    logic       ireq1;
    logic       irs0;
    logic       irs1;
    logic [7:0] idata0;
    logic [7:0] idata1;
    logic       ilast0;
    logic       ilast1;
    logic       oack0;
    logic       oack1;
    logic [1:0] ogrant;
    logic [7:0] odata;
    logic       ors;
    logic       ostart;
    logic       idone;
    logic       obusy;
    logic       oerr;

    // Arbiter side.
    modport slave (
        input  ireq0, ireq1, irs0, irs1, idata0, idata1, ilast0, ilast1, idone,
        output oack0, oack1, ogrant, odata, ors, ostart, obusy, oerr
    );

    // Requesters plus write engine.
    modport master (
        output ireq0, ireq1, irs0, irs1, idata0, idata1, ilast0, ilast1, idone,
        input  oack0, oack1, ogrant, odata, ors, ostart, obusy, oerr
    );
endinterface

// File: rtl/lcd_cmd_arbiter.sv
// rtl/lcd_cmd_arbiter.sv - two-requester burst arbiter and byte sequencer for lcd_controller
// Optional idone watchdog enabled by defining LCD_ARB_WDOG_EN.
module lcd_cmd_arbiter #(
    parameter int DLY_CYCLES  = 262143,
    parameter int WDOG_CYCLES = 65535
) (
    input  logic             iclk,
    input  logic             irst_n,
    lcd_cmd_arbiter_if.slave bus
);
    localparam int MAX_CYC = (DLY_CYCLES > WDOG_CYCLES) ? DLY_CYCLES : WDOG_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] DLY_LAST = CW'(DLY_CYCLES - 1);
`ifdef LCD_ARB_WDOG_EN
    localparam logic [CW-1:0] WDOG_LAST = CW'(WDOG_CYCLES - 1);
`endif

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_WAIT_DONE = 3'd1;
    localparam logic [2:0] S_SETTLE    = 3'd2;
    localparam logic [2:0] S_ACK       = 3'd3;
    localparam logic [2:0] S_HOLD      = 3'd4;

    logic [2:0]    state;
    logic          owner;
    logic          last_q;
    logic          rr;
    logic [CW-1:0] cnt;
    logic          pick;
    logic          own_req;
    logic [7:0]    own_data;
    logic          own_rs;
    logic          own_last;

    // Contention goes to the round-robin pointer; otherwise whoever asks.
    assign pick     = (bus.ireq0 && bus.ireq1) ? rr : bus.ireq1;
    assign own_req  = owner ? bus.ireq1  : bus.ireq0;
    assign own_data = owner ? bus.idata1 : bus.idata0;
    assign own_rs   = owner ? bus.irs1   : bus.irs0;
    assign own_last = owner ? bus.ilast1 : bus.ilast0;

    assign bus.obusy = (state != S_IDLE);

`ifdef LCD_ARB_WDOG_EN
    logic err_q;
    assign bus.oerr = err_q;
`else
    assign bus.oerr = 1'b0;
`endif

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state      <= S_IDLE;
            owner      <= 1'b0;
            last_q     <= 1'b0;
            rr         <= 1'b0;
            cnt        <= '0;
            bus.ostart <= 1'b0;
            bus.ors    <= 1'b0;
            bus.odata  <= 8'h00;
            bus.ogrant <= 2'b00;
            bus.oack0  <= 1'b0;
            bus.oack1  <= 1'b0;
`ifdef LCD_ARB_WDOG_EN
            err_q      <= 1'b0;
`endif
        end else begin
            bus.oack0 <= 1'b0;
            bus.oack1 <= 1'b0;
`ifdef LCD_ARB_WDOG_EN
            err_q     <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (bus.ireq0 || bus.ireq1) begin
                        owner      <= pick;
                        bus.ogrant <= pick ? 2'b10 : 2'b01;
                        bus.odata  <= pick ? bus.idata1 : bus.idata0;
                        bus.ors    <= pick ? bus.irs1 : bus.irs0;
                        last_q     <= pick ? bus.ilast1 : bus.ilast0;
                        bus.ostart <= 1'b1;
                        cnt        <= '0;
                        state      <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.idone) begin
                        bus.ostart <= 1'b0;
                        cnt        <= '0;
                        state      <= S_SETTLE;
                    end
`ifdef LCD_ARB_WDOG_EN
                    // Controller never answered: drop the whole burst.
                    else if (cnt == WDOG_LAST) begin
                        bus.ostart <= 1'b0;
                        bus.ogrant <= 2'b00;
                        err_q      <= 1'b1;
                        rr         <= ~owner;
                        cnt        <= '0;
                        state      <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                S_SETTLE: begin
                    if (cnt == DLY_LAST) begin
                        cnt       <= '0;
                        bus.oack0 <= ~owner;
                        bus.oack1 <= owner;
                        state     <= S_ACK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    if (last_q) begin
                        bus.ogrant <= 2'b00;
                        rr         <= ~owner;
                        state      <= S_IDLE;
                    end else begin
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (own_req) begin
                        bus.odata  <= own_data;
                        bus.ors    <= own_rs;
                        last_q     <= own_last;
                        bus.ostart <= 1'b1;
                        cnt        <= '0;
                        state      <= S_WAIT_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// tb/tb_lcd_cmd_arbiter.sv - directed self-checking bench for lcd_cmd_arbiter (DLY_CYCLES=4, WDOG_CYCLES=16)
module tb_lcd_cmd_arbiter;
    logic iclk = 1'b0;
    logic irst_n = 1'b0;
    always #5 iclk = ~iclk;

    lcd_cmd_arbiter_if bus ();

    lcd_cmd_arbiter #(.DLY_CYCLES(4), .WDOG_CYCLES(16)) dut (
        .iclk   (iclk),
        .irst_n (irst_n),
        .bus    (bus)
    );

    // Write engine: idone sampled on the third edge after ostart rises.
    logic       model_en = 1'b1;
    logic [3:0] mcnt = 4'd0;
    always @(posedge iclk) begin
        if (!bus.ostart) mcnt <= 4'd0;
        else if (mcnt != 4'hf) mcnt <= mcnt + 4'd1;
    end
    assign bus.idone = model_en && bus.ostart && (mcnt == 4'd2);

    int n_tests = 0;
    int n_fail  = 0;
    int ack0_cnt = 0;
    int ack1_cnt = 0;
    int err_cnt  = 0;
    logic       start_q = 1'b0;
    logic [7:0] log_data[$];
    logic       log_rs[$];
    logic [1:0] log_grant[$];

    always @(negedge iclk) begin
        if (bus.oack0) ack0_cnt++;
        if (bus.oack1) ack1_cnt++;
        if (bus.oerr) err_cnt++;
        if (irst_n && bus.ostart && !start_q) begin
            log_data.push_back(bus.odata);
            log_rs.push_back(bus.ors);
            log_grant.push_back(bus.ogrant);
        end
        start_q = bus.ostart;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic on, input logic rs, input logic [7:0] d, input logic last);
        if (id == 0) begin
            bus.ireq0 = on; bus.irs0 = rs; bus.idata0 = d; bus.ilast0 = last;
        end else begin
            bus.ireq1 = on; bus.irs1 = rs; bus.idata1 = d; bus.ilast1 = last;
        end
    endtask

    task automatic wait_ostart(input int cap, output int hi);
        int seen;
        seen = 0;
        hi = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge iclk);
            if (bus.ostart) begin seen = 1; break; end
        end
        if (seen == 0) check("ostart_timeout", 0, 1);
        else begin
            hi = 1;
            while (hi < cap) begin
                @(negedge iclk);
                if (bus.ostart) hi++;
                else break;
            end
        end
    endtask

    task automatic wait_ack(input int id, output int cyc);
        cyc = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge iclk);
            if ((id == 0 && bus.oack0) || (id == 1 && bus.oack1)) begin cyc = i; break; end
        end
        if (cyc < 0) check(id == 0 ? "ack0_timeout" : "ack1_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge iclk);
        irst_n = 1'b0;
        set_req(0, 0, 0, 8'h00, 0);
        set_req(1, 0, 0, 8'h00, 0);
        repeat (2) @(negedge iclk);
        irst_n = 1'b1;
        log_data.delete(); log_rs.delete(); log_grant.delete();
    endtask

    int hi, cyc, a0, a1, e0, ls;

    initial begin
        set_req(0, 0, 0, 8'h00, 0);
        set_req(1, 0, 0, 8'h00, 0);
        do_reset();
        check("rst_ostart", bus.ostart, 0);
        check("rst_ogrant", bus.ogrant, 0);
        check("rst_obusy",  bus.obusy, 0);
        check("rst_odata",  bus.odata, 0);
        check("rst_oack",   {bus.oack0, bus.oack1}, 0);
        check("rst_oerr",   bus.oerr, 0);

        // Single command byte
        @(posedge iclk); #1 set_req(0, 1, 0, 8'h38, 1);
        wait_ostart(100, hi);
        check("single_ostart_cycles", hi, 3);
        wait_ack(0, cyc);
        check("single_ack_delay", cyc, 4);
        @(posedge iclk); #1 set_req(0, 0, 0, 8'h38, 1);
        @(negedge iclk);
        check("single_ack_width", bus.oack0, 0);
        check("single_grant_idle", bus.ogrant, 0);
        check("single_busy_idle", bus.obusy, 0);
        check("single_log_n", log_data.size(), 1);
        check("single_data", log_data[0], 8'h38);
        check("single_rs", log_rs[0], 0);
        check("single_grant", log_grant[0], 2'b01);

        // Locked burst with a competing request during byte 2
        do_reset();
        a0 = ack0_cnt;
        @(posedge iclk); #1 set_req(0, 1, 1, 8'h61, 0);
        wait_ack(0, cyc);
        @(posedge iclk); #1 set_req(0, 1, 1, 8'h6c, 0);
        set_req(1, 1, 0, 8'h55, 1);
        wait_ack(0, cyc);
        @(posedge iclk); #1 set_req(0, 1, 1, 8'h74, 1);
        wait_ack(0, cyc);
        check("burst_grant_at_ack3", bus.ogrant, 2'b01);
        @(posedge iclk); #1 set_req(0, 0, 0, 8'h00, 0);
        @(negedge iclk);
        check("burst_grant_gap", bus.ogrant, 2'b00);
        @(negedge iclk);
        check("burst_grant_next", bus.ogrant, 2'b10);
        wait_ack(1, cyc);
        @(posedge iclk); #1 set_req(1, 0, 0, 8'h00, 0);
        repeat (2) @(negedge iclk);
        check("burst_ack0_n", ack0_cnt - a0, 3);
        check("burst_log_n", log_data.size(), 4);
        check("burst_b0", {log_grant[0], log_rs[0], log_data[0]}, {2'b01, 1'b1, 8'h61});
        check("burst_b1", {log_grant[1], log_rs[1], log_data[1]}, {2'b01, 1'b1, 8'h6c});
        check("burst_b2", {log_grant[2], log_rs[2], log_data[2]}, {2'b01, 1'b1, 8'h74});
        check("burst_r1", {log_grant[3], log_rs[3], log_data[3]}, {2'b10, 1'b0, 8'h55});

        // Simultaneous requests right after reset, twice
        do_reset();
        @(posedge iclk); #1 set_req(0, 1, 0, 8'h01, 1); set_req(1, 1, 1, 8'h02, 1);
        wait_ack(0, cyc);
        @(posedge iclk); #1 set_req(0, 0, 0, 8'h00, 0);
        wait_ack(1, cyc);
        @(posedge iclk); #1 set_req(1, 0, 0, 8'h00, 0);
        @(posedge iclk); #1 set_req(0, 1, 0, 8'h03, 1); set_req(1, 1, 1, 8'h04, 1);
        wait_ack(0, cyc);
        @(posedge iclk); #1 set_req(0, 0, 0, 8'h00, 0);
        wait_ack(1, cyc);
        @(posedge iclk); #1 set_req(1, 0, 0, 8'h00, 0);
        repeat (2) @(negedge iclk);
        check("simul_log_n", log_data.size(), 4);
        check("simul_first", {log_grant[0], log_data[0]}, {2'b01, 8'h01});
        check("simul_second", {log_grant[1], log_data[1]}, {2'b10, 8'h02});
        check("simul_again", {log_grant[2], log_data[2]}, {2'b01, 8'h03});
        check("simul_again2", {log_grant[3], log_data[3]}, {2'b10, 8'h04});

        // Asynchronous reset during SETTLE
        a0 = ack0_cnt; a1 = ack1_cnt;
        @(posedge iclk); #1 set_req(0, 1, 0, 8'h99, 0);
        wait_ostart(100, hi);
        @(negedge iclk);
        irst_n = 1'b0;
        set_req(0, 0, 0, 8'h00, 0);
        #1;
        check("mid_rst_ostart", bus.ostart, 0);
        check("mid_rst_ogrant", bus.ogrant, 0);
        check("mid_rst_oack", {bus.oack0, bus.oack1}, 0);
        check("mid_rst_obusy", bus.obusy, 0);
        @(negedge iclk);
        irst_n = 1'b1;
        ls = log_data.size();
        repeat (20) @(negedge iclk);
        check("mid_rst_no_ack", (ack0_cnt - a0) + (ack1_cnt - a1), 0);
        check("mid_rst_no_start", log_data.size(), ls);

        // idone never arrives
        do_reset();
        model_en = 1'b0;
        a0 = ack0_cnt; e0 = err_cnt;
        @(posedge iclk); #1 set_req(0, 1, 0, 8'h5a, 1);
`ifdef LCD_ARB_WDOG_EN
        wait_ostart(1100, hi);
        set_req(0, 0, 0, 8'h00, 0);
        check("wdog_ostart_cycles", hi, 16);
        check("wdog_oerr_pulse", bus.oerr, 1);
        @(negedge iclk);
        check("wdog_oerr_width", bus.oerr, 0);
        check("wdog_idle", bus.obusy, 0);
        repeat (10) @(negedge iclk);
        check("wdog_err_n", err_cnt - e0, 1);
        check("wdog_no_ack", ack0_cnt - a0, 0);
        check("wdog_no_regrant", bus.ostart, 0);
`else
        wait_ostart(1000, hi);
        check("nowdog_ostart_cycles", hi, 1000);
        check("nowdog_ostart_high", bus.ostart, 1);
        check("nowdog_oerr", err_cnt - e0, 0);
        check("nowdog_no_ack", ack0_cnt - a0, 0);
`endif
        model_en = 1'b1;
        do_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lcd_cmd_arbiter.md
# lcd_cmd_arbiter

Two-requester arbiter and byte sequencer in front of `lcd_controller`. It lets an init/static-text sequencer and a dynamic-field updater share one LCD write engine. Each requester submits bursts of bytes (command or data). The block issues each byte to the controller with a start/done handshake, then applies the mandatory LCD settle delay, then acknowledges the requester.

## Interface
Parameters:
- `DLY_CYCLES`, 262143 — post-write settle cycles after `idone`; legal range ≥1.
- `WDOG_CYCLES`, 65535 — watchdog limit on cycles spent waiting for `idone`; used only with `LCD_ARB_WDOG_EN`.

Ports:
- `iclk` in 1 — clock.
- `irst_n` in 1 — reset; asynchronous, active-low.
- `ireq0` / `ireq1` in 1 — requester N has a byte pending.
- `irs0` / `irs1` in 1 — byte type for requester N: 0 = command, 1 = data.
- `idata0` / `idata1` in 8 — byte from requester N.
- `ilast0` / `ilast1` in 1 — current byte ends requester N's burst.
- `oack0` / `oack1` out 1 — one-cycle pulse: byte fully written and settled.
- `ogrant` out 2 — one-hot burst owner; 0 when idle.
- `odata` out 8 — to controller `idata`.
- `ors` out 1 — to controller `irs`.
- `ostart` out 1 — to controller `istart`.
- `idone` in 1 — from controller `odone`.
- `obusy` out 1 — high whenever state ≠ IDLE.
- `oerr` out 1 — one-cycle pulse on watchdog abort.

## Operation
- FSM states: IDLE, WAIT_DONE, SETTLE, ACK, HOLD.
- **IDLE**
  - Arbitration: if only one `ireqN` is high, grant N. If both are high, grant the requester selected by round-robin pointer `rr`.
  - On grant, at the same edge: set `ogrant`, register `odata`/`ors` from the owner's inputs, set `ostart <= 1`, go to WAIT_DONE.
- **WAIT_DONE**
  - Hold `ostart` high until `idone` is sampled high.
  - Then: `ostart <= 0`, clear the counter, go to SETTLE.
- **SETTLE**
  - Count `DLY_CYCLES` cycles, then go to ACK.
- **ACK**
  - Registered `oackN` pulse for the owner, lasting exactly one cycle.
  - If the latched `last` bit is 1: go to IDLE, clear `ogrant`, set `rr <= ~owner`.
  - Otherwise go to HOLD.
- **HOLD**
  - Burst is locked. The other requester is never granted.
  - When the owner's `ireq` is high: latch `idata`/`irs`/`ilast`, set `ostart <= 1`, go to WAIT_DONE.
- Requester contract: hold `ireq`/`irs`/`idata`/`ilast` stable until `oack`. The inputs are sampled once, at issue.
- Dropping `ireq` after issue does not cancel the byte; `oack` still pulses.
- A single counter of width `$clog2(max(DLY_CYCLES, WDOG_CYCLES)+1)` serves both SETTLE and the watchdog.
- Reset (asynchronous, any state, including mid-burst):
  - State = IDLE.
  - `ostart`, `ors`, `odata`, `ogrant`, `oack0`/`oack1`, `oerr` = 0; `obusy` = 0.
  - `rr` = 0 (requester 0 is preferred first); counter = 0.

## Timing
- `ireqN` sampled high in IDLE at edge k → `ogrant` / `odata` / `ostart` valid after edge k.
- `idone` sampled high at edge m → `ostart` low after m.
- SETTLE lasts exactly `DLY_CYCLES` cycles after m.
- `oack` high for the single following cycle.
- Byte-to-byte within a burst: next `ostart` rises the cycle after HOLD samples `ireq`. Minimum gap is 1 cycle after `oack` falls.
- `idone` outside WAIT_DONE is ignored.
- Both `ireq` rise in the same cycle while idle → only the `rr` requester is granted. The other waits through the whole burst, then wins next, because `rr` has flipped.
- A request from the non-owner during a burst is never lost. It is granted on the IDLE cycle after the burst's ACK.

## Configuration
- Macro: `LCD_ARB_WDOG_EN`.
- **Defined:**
  - The counter runs in WAIT_DONE.
  - If it reaches `WDOG_CYCLES` without `idone`: `ostart <= 0`, `oerr` pulses one cycle, no `oack`, the burst is aborted, `rr <= ~owner`, go to IDLE.
- **Undefined:**
  - WAIT_DONE waits indefinitely.
  - `oerr` is tied to 0.
  - `WDOG_CYCLES` is unused.

## Test plan
All scenarios use `DLY_CYCLES=4` and a controller model that returns `idone` 3 cycles after `ostart` rises, except where stated.
- **Single byte:** req0 only, `irs0=0`, `idata0=8'h38`, `ilast0=1`.
  - `odata=8'h38`, `ors=0`, `ostart` high 3 cycles.
  - `oack0` pulses exactly 4 cycles after `idone`.
  - `ogrant` back to 0, `obusy` low.
- **Locked burst:** req0 burst of 3 data bytes ("a","l","t"), with req1 raised during byte 2.
  - Exactly 3 `ostart` pulses carry 8'h61, 8'h6c, 8'h74, all with `ors=1`.
  - `ogrant=2'b10` only after the third `oack0`.
- **Simultaneous request after reset:** req0 and req1 both raised.
  - Requester 0 is served first, then requester 1.
  - Raise both again → requester 0 is served, since `rr` has returned to 0.
- **Reset mid-burst:** assert `irst_n=0` during SETTLE.
  - Immediately: `ostart`, `ogrant`, `oack0`, `oack1`, `obusy` = 0.
  - After release: no `oack` without a new request.
- **Watchdog** (`LCD_ARB_WDOG_EN` defined, `WDOG_CYCLES=16`), model never asserts `idone`:
  - `ostart` drops after 16 cycles, `oerr` pulses once, no `oack`, state returns to IDLE.
  - Same stimulus without the macro → `ostart` stays high for 1000 cycles and `oerr=0`.
